pipe_stage_reg: RTL

//  Generic parametrised pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers: the EX/MEM
// payload layout, the NOP encoding and the stage occupancy encoding.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [31:0] instr;
        logic [4:0]  write_reg;
        logic [4:0]  rd;
    } exmem_payload_t;

    localparam int EXMEM_W = $bits(exmem_payload_t);
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Stage state doubles as the occ output: number of entries held.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble insertion.
// Define PIPE_SKID_EN to add a skid slot so up_ready has no path from dn_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W          = EXMEM_W,
    parameter logic [DATA_W-1:0] RESET_VAL       = '0,
    parameter bit                CLEAR_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occ
);

    occ_state_t        state_reg, state_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [DATA_W-1:0] bubble_data;
    logic              push, pop;

    assign dn_valid    = (state_reg != OCC_EMPTY);
    assign dn_data     = main_data_reg;
    assign occ         = state_reg;
    assign push        = up_valid & up_ready;
    assign pop         = dn_valid & dn_ready;
    assign bubble_data = CLEAR_ON_BUBBLE ? RESET_VAL : main_data_reg;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;

    // Ready depends only on registered state, which breaks the stall path.
    assign up_ready = (state_reg != OCC_FULL);

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        case (state_reg)
            OCC_EMPTY: begin
                if (push) begin
                    state_next     = OCC_ONE;
                    main_data_next = up_data;
                end
            end
            OCC_ONE: begin
                if (push && !pop) begin
                    state_next     = OCC_FULL;
                    skid_data_next = up_data;
                end else if (push && pop) begin
                    main_data_next = up_data;
                end else if (pop) begin
                    state_next     = OCC_EMPTY;
                    main_data_next = bubble_data;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    state_next     = OCC_ONE;
                    main_data_next = skid_data_reg;
                    skid_data_next = RESET_VAL;
                end
            end
            default: begin
                state_next     = OCC_EMPTY;
                main_data_next = RESET_VAL;
                skid_data_next = RESET_VAL;
            end
        endcase
        // Flush drops everything, including a same-cycle upstream transfer.
        if (flush) begin
            state_next     = OCC_EMPTY;
            main_data_next = RESET_VAL;
            skid_data_next = RESET_VAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_data_reg <= RESET_VAL;
        end else begin
            skid_data_reg <= skid_data_next;
        end
    end
`else
    // Single slot: a full slot can still accept when it is draining this cycle.
    assign up_ready = !dn_valid | dn_ready;

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        if (push) begin
            state_next     = OCC_ONE;
            main_data_next = up_data;
        end else if (pop) begin
            state_next     = OCC_EMPTY;
            main_data_next = bubble_data;
        end
        if (flush) begin
            state_next     = OCC_EMPTY;
            main_data_next = RESET_VAL;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= OCC_EMPTY;
            main_data_reg <= RESET_VAL;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
        end
    end

endmodule
